btn_sel_ctrl: RTL and testbench

Upstream control stage for the nibble multiplexer/demultiplexer datapath. It synchronises and debounces the five raw push-buttons (btnL, btnU, btnD, btnR, btnC), then drives registered selects and an enable into the datapath:
- mux select = {U, L}
- demux select = {R, D}
- enable = C

It also emits a one-cycle pulse whenever any of these outputs changes, so downstream logic and benches can sample a settled configuration.

---
 rtl/btn_sel_ctrl_pkg.sv | 20 ++
 rtl/btn_sel_ctrl_if.sv | 29 ++
 rtl/btn_sel_ctrl_debounce.sv | 62 ++++++
 rtl/btn_sel_ctrl.sv | 99 +++++++++
 tb/tb_btn_sel_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/btn_sel_ctrl_pkg.sv
// Shared constants and types for the button select controller.
// Holds the default debounce length, the 2-bit select code type and the
// bit position of each button within the 5-bit button/output vector.
package btn_pkg;

  // 10 ms at 100 MHz
  localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;

  localparam int N_BTN = 5;

  // Bit index of each button within the 5-bit vector
  localparam int BTN_L = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_R = 3;
  localparam int BTN_C = 4;

  typedef logic [1:0] sel_code_t;

endpackage

// File: rtl/btn_sel_ctrl_if.sv
// Select bus between btn_sel_ctrl and the nibble mux/demux datapath.
// The controller (master) drives registered selects and enable; the datapath
// (slave) only observes them. There is no backpressure: sel_change is a
// one-cycle qualifier that is high the cycle after any select/enable bit
// changed, so a consumer sampling while sel_change is high sees the settled
// new configuration.
interface btn_sel_ctrl_if;
  import btn_pkg::*;

  sel_code_t mux_sel;
  sel_code_t demux_sel;
  logic      enable;
  logic      sel_change;

  modport master (
    output mux_sel,
    output demux_sel,
    output enable,
    output sel_change
  );

  modport slave (
    input mux_sel,
    input demux_sel,
    input enable,
    input sel_change
  );

endinterface

// File: rtl/btn_sel_ctrl_debounce.sv
// One push-button channel: two-flop synchroniser, consecutive-cycle debounce
// counter and stable level register. 'rise' is high during the cycle whose
// clock edge flips the stable level from 0 to 1, so a consumer register
// updated on 'rise' changes on the same edge as 'level'.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync;

  assign sync = sync_q[1];

  // Shift the raw button through the two synchroniser stages
  always_comb begin
    sync_d = {sync_q[0], btn_raw};
  end

  // Count consecutive disagreeing cycles; flip stable on the terminal count
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Channel state registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign rise  = stable_d & ~stable_q;

endmodule

// File: rtl/btn_sel_ctrl.sv
// Button select controller: debounces the five raw buttons and drives the
// datapath selects mux_sel={U,L}, demux_sel={R,D} and enable=C, plus a
// one-cycle sel_change pulse after any of them changes.
// Build option: define BTN_TOGGLE_EN for toggle mode, where each output bit
// inverts on its button's press and ignores releases.
module btn_sel_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      btnL,
  input  logic      btnU,
  input  logic      btnD,
  input  logic      btnR,
  input  logic      btnC,
  output sel_code_t mux_sel,
  output sel_code_t demux_sel,
  output logic      enable,
  output logic      sel_change
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] out_vec;
  logic [N_BTN-1:0] prev_q, prev_d;
  logic             sel_change_q, sel_change_d;

  assign btn_raw[BTN_L] = btnL;
  assign btn_raw[BTN_U] = btnU;
  assign btn_raw[BTN_D] = btnD;
  assign btn_raw[BTN_R] = btnR;
  assign btn_raw[BTN_C] = btnC;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_raw[i]),
      .level   (level[i]),
      .rise    (rise[i])
    );
  end

`ifdef BTN_TOGGLE_EN
  logic [N_BTN-1:0] tog_q, tog_d;
  logic             unused_level;

  // Invert each latched bit on its channel's press; releases are ignored
  always_comb begin
    tog_d = tog_q ^ rise;
  end

  // Toggle state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_q <= '0;
    end else begin
      tog_q <= tog_d;
    end
  end

  assign out_vec      = tog_q;
  assign unused_level = ^level;
`else
  logic unused_rise;

  // Level mode: outputs follow the stable registers directly
  assign out_vec     = level;
  assign unused_rise = ^rise;
`endif

  // Compare the output vector with last cycle's copy; one pulse per change edge
  always_comb begin
    prev_d       = out_vec;
    sel_change_d = (out_vec != prev_q);
  end

  // Change detector registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q       <= '0;
      sel_change_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      sel_change_q <= sel_change_d;
    end
  end

  assign mux_sel    = {out_vec[BTN_U], out_vec[BTN_L]};
  assign demux_sel  = {out_vec[BTN_R], out_vec[BTN_D]};
  assign enable     = out_vec[BTN_C];
  assign sel_change = sel_change_q;

endmodule

// File: tb/tb_btn_sel_ctrl.sv
// Bench for btn_sel_ctrl with DEBOUNCE_CYCLES=4. A behavioural model keeps a
// sliding window of the last D synchronised samples per button and flips the
// stable level when the whole window disagrees with it.
module tb_btn_sel_ctrl;
  import btn_pkg::*;

  localparam int D = 4;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn_vec = '0;

  always #5 clk = ~clk;

  btn_sel_ctrl_if sel_if ();

  btn_sel_ctrl #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btnL       (btn_vec[BTN_L]),
    .btnU       (btn_vec[BTN_U]),
    .btnD       (btn_vec[BTN_D]),
    .btnR       (btn_vec[BTN_R]),
    .btnC       (btn_vec[BTN_C]),
    .mux_sel    (sel_if.mux_sel),
    .demux_sel  (sel_if.demux_sel),
    .enable     (sel_if.enable),
    .sel_change (sel_if.sel_change)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model state
  logic [4:0] m_s1, m_s2;
  logic [4:0] m_stable, m_tog, m_prev, m_vec;
  logic       m_chg;
  logic [4:0] m_win[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_tog = '0;
    m_prev = '0; m_vec = '0; m_chg = 1'b0;
    m_win.delete();
  endtask

  // One rising edge of the model, using the raw buttons present at the edge
  task automatic model_edge();
    logic [4:0] vec_old, new_stable, rise;
    logic       all_diff;
    vec_old = m_vec;
    m_win.push_back(m_s2);
    if (m_win.size() > D) void'(m_win.pop_front());
    new_stable = m_stable;
    rise = '0;
    if (m_win.size() == D) begin
      for (int b = 0; b < 5; b++) begin
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) begin
          new_stable[b] = ~m_stable[b];
          rise[b] = new_stable[b];
        end
      end
    end
    m_stable = new_stable;
    m_tog = m_tog ^ rise;
    m_s2 = m_s1;
    m_s1 = btn_vec;
    m_chg = (vec_old != m_prev);
    m_prev = vec_old;
`ifdef BTN_TOGGLE_EN
    m_vec = m_tog;
`else
    m_vec = m_stable;
`endif
  endtask

  task automatic check_model();
    chk("model_mux_sel", sel_if.mux_sel, {m_vec[BTN_U], m_vec[BTN_L]});
    chk("model_demux_sel", sel_if.demux_sel, {m_vec[BTN_R], m_vec[BTN_D]});
    chk("model_enable", sel_if.enable, m_vec[BTN_C]);
    chk("model_sel_change", sel_if.sel_change, m_chg);
  endtask

  // Driver: advance one clock, step the model, sample 1 time unit later
  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    if (sel_if.sel_change === 1'b1) pulses++;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_model();
  endtask

  initial begin
    model_reset();

    // Reset with every button held: all outputs resolve 6 cycles after release
    btn_vec = 5'h1F;
    #2;
    do_reset();
    chk("rst_release_mux", sel_if.mux_sel, 0);
    chk("rst_release_demux", sel_if.demux_sel, 0);
    chk("rst_release_en", sel_if.enable, 0);
    chk("rst_release_chg", sel_if.sel_change, 0);
    repeat (5) step();
    chk("rst_c5_mux", sel_if.mux_sel, 0);
    step();
    chk("rst_c6_mux", sel_if.mux_sel, 3);
    chk("rst_c6_demux", sel_if.demux_sel, 3);
    chk("rst_c6_en", sel_if.enable, 1);
    chk("rst_c6_chg", sel_if.sel_change, 0);
    step();
    chk("rst_c7_chg", sel_if.sel_change, 1);
    step();
    chk("rst_c8_chg", sel_if.sel_change, 0);

    // Clean press of btnU
    btn_vec = '0;
    do_reset();
    repeat (3) step();
    btn_vec[BTN_U] = 1'b1;
    repeat (5) step();
    chk("press_c5_mux", sel_if.mux_sel, 0);
    step();
    chk("press_c6_mux", sel_if.mux_sel, 2);
    chk("press_c6_chg", sel_if.sel_change, 0);
    step();
    chk("press_c7_chg", sel_if.sel_change, 1);
    step();
    chk("press_c8_chg", sel_if.sel_change, 0);
    repeat (3) step();
    btn_vec[BTN_U] = 1'b0;
    repeat (5) step();
    chk("release_c5_mux", sel_if.mux_sel, 2);
    step();
`ifdef BTN_TOGGLE_EN
    chk("release_hold_mux", sel_if.mux_sel, 2);
    repeat (4) step();
    btn_vec[BTN_U] = 1'b1;
    repeat (6) step();
    chk("press2_mux", sel_if.mux_sel, 0);
    btn_vec[BTN_U] = 1'b0;
`else
    chk("release_c6_mux", sel_if.mux_sel, 0);
`endif
    repeat (8) step();

    // Bounce rejection on btnL: 3 high, 1 low, 3 high, then low
    pulses = 0;
    btn_vec[BTN_L] = 1'b1;
    repeat (3) step();
    btn_vec[BTN_L] = 1'b0;
    step();
    btn_vec[BTN_L] = 1'b1;
    repeat (3) step();
    btn_vec[BTN_L] = 1'b0;
    repeat (10) step();
    chk("bounce_mux", sel_if.mux_sel, 0);
    chk("bounce_pulses", pulses, 0);

    // Simultaneous press of btnD and btnR
    pulses = 0;
    btn_vec[BTN_D] = 1'b1;
    btn_vec[BTN_R] = 1'b1;
    repeat (5) step();
    chk("simul_c5_demux", sel_if.demux_sel, 0);
    step();
    chk("simul_c6_demux", sel_if.demux_sel, 3);
    repeat (4) step();
    chk("simul_pulses", pulses, 1);
    btn_vec = '0;
    repeat (10) step();

    // Mid-count reset with btnC held
    btn_vec[BTN_C] = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_en", sel_if.enable, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) step();
    chk("midrst_c5_en", sel_if.enable, 0);
    step();
    chk("midrst_c6_en", sel_if.enable, 1);
    btn_vec = '0;
    repeat (10) step();

    // Randomised button activity against the model
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 5) == 0) btn_vec[b] = ~btn_vec[b];
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
